// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit loads/stores over a 16-bit SRAM as two fixed-wait half-word
// accesses, upstream freeze while busy, and the MEM/WB pipeline register.
module mem_stage_sram #(
  parameter int BIT_NUMBER  = 32,
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 4,
  parameter int SRAM_AW     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [BIT_NUMBER-1:0] alu_result_in,
  input  logic [BIT_NUMBER-1:0] val_rm_in,
  input  logic [3:0]            dest_in,
  output logic                  freeze,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [15:0]           sram_wdata,
  input  logic [15:0]           sram_rdata,
  output logic                  sram_we_n,
  output logic                  sram_oe_n,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic [BIT_NUMBER-1:0] alu_result,
  output logic [BIT_NUMBER-1:0] mem_data,
  output logic [3:0]            dest
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [BIT_NUMBER-1:0] buffer;
  logic [BIT_NUMBER-1:0] word;
  logic                  mem_req, is_store, is_load, cnt_last, fsm_freeze;

  assign mem_req  = mem_w_en_in | mem_r_en_in;
  // A simultaneous read+write request behaves as a store.
  assign is_store = mem_w_en_in;
  assign is_load  = mem_r_en_in & ~mem_w_en_in;
  assign cnt_last = (cnt == CNT_LAST);
  assign word     = (alu_result_in - BIT_NUMBER'(ADDR_BASE)) >> 2;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    fsm_freeze = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    case (state)
      IDLE: begin
        if (mem_req) begin
          state_nxt  = LO;
          cnt_nxt    = '0;
          fsm_freeze = 1'b1;
        end
      end
      LO, HI: begin
        fsm_freeze = 1'b1;
        sram_addr  = {word[SRAM_AW-2:0], (state == HI)};
        if (is_store) begin
          sram_we_n  = 1'b0;
          sram_wdata = (state == HI) ? val_rm_in[31:16] : val_rm_in[15:0];
        end
        if (is_load) sram_oe_n = 1'b0;
        if (cnt_last) begin
          cnt_nxt   = '0;
          state_nxt = (state == LO) ? HI : DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset must drop the stall at once even with a request still presented.
  assign freeze = fsm_freeze & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      buffer <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (is_load && cnt_last) begin
        if (state == LO) buffer[15:0]  <= sram_rdata;
        if (state == HI) buffer[31:16] <= sram_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      alu_result <= '0;
      mem_data   <= '0;
      dest       <= '0;
    end else if (freeze) begin
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      dest     <= '0;
    end else begin
      wb_en      <= wb_en_in;
      mem_r_en   <= mem_r_en_in;
      alu_result <= alu_result_in;
      mem_data   <= buffer;
      dest       <= dest_in;
    end
  end

endmodule
